// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one 7-bit UART transmitter between up to four
// character sources, with optional message locking so strings never interleave.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 8,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [7*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [6:0]             tx_data,
  input  logic                   tx_busy,
  output logic [1:0]             grant_id,
  output logic                   active,
  output logic                   locked,
  output logic                   err_nostart,
  output logic                   err_lock_to
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] LOCKED    = 3'd4;

  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

  logic [2:0]      state;
  logic [1:0]      rr_ptr;
  logic            last_q;
  logic [BW-1:0]   busy_cnt;
  logic [LW-1:0]   lock_cnt;

  logic [3:0]      valid4, last4;
  logic [3:0][6:0] data4;
  logic [2:0]      cand;
  logic [1:0]      pick, gsel, next_ptr;
  logic            pick_ok, grant_go;
  logic [3:0]      gsel_oh;

  // Widen request buses to a fixed four slots so indexing is uniform for any NUM_REQ.
  always_comb begin
    valid4 = '0;
    last4  = '0;
    data4  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid4[i] = req_valid[i];
      last4[i]  = req_last[i];
      data4[i]  = req_data[7*i +: 7];
    end
  end

  // Scan downward in distance from rr_ptr so the nearest valid requester wins last.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (valid4[cand[1:0]]) begin
        pick    = cand[1:0];
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    gsel     = (state == LOCKED) ? grant_id : pick;
    gsel_oh  = 4'b0001 << gsel;
    next_ptr = (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
    grant_go = !tx_busy &&
               (((state == IDLE) && pick_ok) || ((state == LOCKED) && valid4[grant_id]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      last_q      <= 1'b0;
      busy_cnt    <= '0;
      lock_cnt    <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      locked      <= 1'b0;
      err_nostart <= 1'b0;
      err_lock_to <= 1'b0;
    end else begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      err_nostart <= 1'b0;
      err_lock_to <= 1'b0;
      if (grant_go) begin
        req_ready <= gsel_oh[NUM_REQ-1:0];
        tx_data   <= data4[gsel];
        grant_id  <= gsel;
        last_q    <= last4[gsel];
        active    <= 1'b1;
        state     <= LAUNCH;
      end else begin
        case (state)
          LAUNCH: begin
            tx_start <= 1'b1;
            busy_cnt <= '0;
            state    <= WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (tx_busy) begin
              state <= WAIT_DONE;
            end else if (busy_cnt == BUSY_LAST) begin
              // Character is dropped; advance the pointer so the victim is not retried first.
              err_nostart <= 1'b1;
              locked      <= 1'b0;
              active      <= 1'b0;
              rr_ptr      <= next_ptr;
              state       <= IDLE;
            end else begin
              busy_cnt <= busy_cnt + 1'b1;
            end
          end
          WAIT_DONE: begin
            if (!tx_busy) begin
              active <= 1'b0;
              if (last_q) begin
                locked <= 1'b0;
                rr_ptr <= next_ptr;
                state  <= IDLE;
              end else begin
                locked   <= 1'b1;
                lock_cnt <= '0;
                state    <= LOCKED;
              end
            end
          end
          LOCKED: begin
            // Stall timer only runs while the owner has nothing to offer.
            if (!valid4[grant_id]) begin
              if (lock_cnt == LOCK_LAST) begin
                err_lock_to <= 1'b1;
                locked      <= 1'b0;
                rr_ptr      <= next_ptr;
                state       <= IDLE;
              end else begin
                lock_cnt <= lock_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a short-frame transmitter model
// and a scoreboard of expected {grant_id, char} per launched frame.
module tb_uart_tx_arbiter;

  localparam int FRAME = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [27:0] req_data;
  logic        tx_start;
  logic [6:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active, locked, err_nostart, err_lock_to;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  src_q[4][$];
  logic [8:0]  exp_q[$];
  bit          xmit_en = 1'b1;
  int          xmit_cnt = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(8), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .locked(locked),
    .err_nostart(err_nostart), .err_lock_to(err_lock_to)
  );

  always #5 clk = ~clk;

  // Requesters: present the head of each queue, pop it on a valid&ready edge.
  initial begin
    logic [3:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      hs = req_valid & req_ready;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[7*i +: 7] = src_q[i][0][6:0];
          req_last[i]        = src_q[i][0][7];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter: busy for FRAME cycles starting the cycle after tx_start.
  initial begin
    logic st;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      st = tx_start;
      #1;
      if (xmit_cnt > 0) xmit_cnt--;
      if (st && xmit_en) xmit_cnt = FRAME;
      tx_busy = (xmit_cnt != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic send(input int r, input logic [6:0] d, input logic last);
    src_q[r].push_back({last, d});
    exp_q.push_back({r[1:0], d});
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!tx_busy && !active) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++;
    if ({tx_start, active, locked, err_nostart, err_lock_to} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {tx_start, active, locked, err_nostart, err_lock_to});
    end
    checks++;
    if (tx_data !== 7'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    bit ok;
    logic [8:0] e;
    int drops;
    send(0, 7'h41, 1'b1);
    @(negedge clk);
    wait_ready(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_ready: no grant within budget"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (req_ready !== 4'b0001 || active !== 1'b1) begin
        errors++; $display("FAIL single_grant: got ready=%b active=%b want 0001/1", req_ready, active);
      end
      @(negedge clk);
      checks++;
      if ({tx_start, req_ready} !== {1'b1, 4'b0}) begin
        errors++; $display("FAIL single_start_latency: got start=%b ready=%b want 1/0000", tx_start, req_ready);
      end
      checks++;
      if ({grant_id, tx_data} !== e) begin errors++; $display("FAIL single_data: got %h want %h", {grant_id, tx_data}, e); end
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b want 0", tx_start); end
    end
    drops = 0;
    for (int k = 0; k < 40; k++) begin
      if (!tx_busy) break;
      if (!active) drops++;
      @(negedge clk);
    end
    checks++;
    if (drops != 0 || tx_busy) begin errors++; $display("FAIL single_active_hold: got drops=%0d busy=%b want 0/0", drops, tx_busy); end
    @(negedge clk);
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL single_active_release: got %b want 0", active); end
    // rr_ptr now points at requester 1, so it wins over 0.
    send(1, 7'h31, 1'b1);
    send(0, 7'h30, 1'b1);
    for (int f = 0; f < 2; f++) begin
      wait_ready(60, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin errors++; $display("FAIL rr_ready[%0d]: no grant within budget", f); end
      else begin
        e = exp_q.pop_front();
        checks++;
        if (req_ready !== (4'b0001 << e[8:7])) begin errors++; $display("FAIL rr_onehot[%0d]: got %b want id %0d", f, req_ready, e[8:7]); end
        @(negedge clk);
        checks++;
        if ({tx_start, grant_id, tx_data} !== {1'b1, e}) begin
          errors++; $display("FAIL rr_frame[%0d]: got start=%b %h want 1 %h", f, tx_start, {grant_id, tx_data}, e);
        end
      end
    end
    wait_idle(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_idle: did not return idle"); end
  endtask

  task automatic test_contention;
    bit ok;
    logic [8:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(0, 7'h61, 1'b1);
    send(1, 7'h62, 1'b1);
    send(2, 7'h63, 1'b1);
    send(3, 7'h64, 1'b1);
    send(0, 7'h65, 1'b1);
    for (int f = 0; f < 5; f++) begin
      wait_ready(60, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin errors++; $display("FAIL contention_ready[%0d]: no grant within budget", f); end
      else begin
        e = exp_q.pop_front();
        checks++;
        if (req_ready !== (4'b0001 << e[8:7])) begin errors++; $display("FAIL contention_onehot[%0d]: got %b want id %0d", f, req_ready, e[8:7]); end
        @(negedge clk);
        checks++;
        if ({tx_start, grant_id, tx_data} !== {1'b1, e}) begin
          errors++; $display("FAIL contention_frame[%0d]: got start=%b %h want 1 %h", f, tx_start, {grant_id, tx_data}, e);
        end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL contention_overlap[%0d]: start while busy=%b", f, tx_busy); end
      end
    end
    wait_idle(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL contention_idle: did not return idle"); end
  endtask

  task automatic test_locked;
    bit ok;
    logic [8:0] e;
    send(2, 7'h48, 1'b0);
    send(2, 7'h49, 1'b1);
    send(0, 7'h5a, 1'b1);
    for (int f = 0; f < 3; f++) begin
      wait_ready(60, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin errors++; $display("FAIL locked_ready[%0d]: no grant within budget", f); end
      else begin
        e = exp_q.pop_front();
        checks++;
        if (req_ready !== (4'b0001 << e[8:7]) || locked !== (f == 1)) begin
          errors++; $display("FAIL locked_grant[%0d]: got ready=%b locked=%b want id %0d locked=%0d", f, req_ready, locked, e[8:7], (f == 1));
        end
        @(negedge clk);
        checks++;
        if ({tx_start, grant_id, tx_data} !== {1'b1, e}) begin
          errors++; $display("FAIL locked_frame[%0d]: got start=%b %h want 1 %h", f, tx_start, {grant_id, tx_data}, e);
        end
      end
    end
    wait_idle(60, ok);
    checks++;
    if (!ok || locked !== 1'b0) begin errors++; $display("FAIL locked_release: idle=%b locked=%b want 1/0", ok, locked); end
  endtask

  task automatic test_nostart;
    bit ok;
    logic [8:0] e;
    int at;
    xmit_en = 1'b0;
    send(1, 7'h78, 1'b1);
    send(2, 7'h79, 1'b1);
    for (int f = 0; f < 2; f++) begin
      wait_ready(60, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin errors++; $display("FAIL nostart_ready[%0d]: no grant within budget", f); end
      else begin
        e = exp_q.pop_front();
        checks++;
        if (req_ready !== (4'b0001 << e[8:7])) begin errors++; $display("FAIL nostart_onehot[%0d]: got %b want id %0d", f, req_ready, e[8:7]); end
        @(negedge clk);
        checks++;
        if ({tx_start, grant_id, tx_data} !== {1'b1, e}) begin
          errors++; $display("FAIL nostart_frame[%0d]: got start=%b %h want 1 %h", f, tx_start, {grant_id, tx_data}, e);
        end
        at = 0;
        for (int k = 1; k <= 12; k++) begin
          @(negedge clk);
          if (err_nostart) begin at = k; break; end
        end
        checks++;
        if (at != 8 || active !== 1'b0) begin
          errors++; $display("FAIL nostart_timing[%0d]: got pulse at %0d active=%b want 8/0", f, at, active);
        end
        @(negedge clk);
        checks++;
        if (err_nostart !== 1'b0) begin errors++; $display("FAIL nostart_width[%0d]: got %b want 0", f, err_nostart); end
      end
    end
    xmit_en = 1'b1;
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nostart_idle: did not return idle"); end
  endtask

  task automatic test_lock_stall;
    bit ok;
    logic [8:0] e;
    int at, stray;
    send(1, 7'h70, 1'b0);
    send(2, 7'h71, 1'b1);
    wait_ready(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_ready: no grant within budget"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_onehot: got %b want 0010", req_ready); end
      @(negedge clk);
      checks++;
      if ({tx_start, grant_id, tx_data} !== {1'b1, e}) begin errors++; $display("FAIL stall_frame: got %h want %h", {grant_id, tx_data}, e); end
    end
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (locked) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_locked: locked never rose"); end
    at = 0;
    stray = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (err_lock_to) begin at = k; break; end
      if (req_ready != 4'b0) stray++;
    end
    checks++;
    if (at != 16 || locked !== 1'b0 || stray != 0) begin
      errors++; $display("FAIL stall_timeout: got pulse at %0d locked=%b stray=%0d want 16/0/0", at, locked, stray);
    end
    wait_ready(20, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin errors++; $display("FAIL stall_next_ready: no grant after timeout"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_next_onehot: got %b want 0100", req_ready); end
      @(negedge clk);
      checks++;
      if ({tx_start, grant_id, tx_data} !== {1'b1, e}) begin errors++; $display("FAIL stall_next_frame: got %h want %h", {grant_id, tx_data}, e); end
    end
    wait_idle(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_idle: did not return idle"); end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    logic [8:0] e;
    int early;
    send(3, 7'h72, 1'b1);
    wait_ready(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_ready: no grant within budget"); end
    else begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if ({tx_start, grant_id, tx_data} !== {1'b1, e}) begin errors++; $display("FAIL midrst_frame: got %h want %h", {grant_id, tx_data}, e); end
    end
    repeat (3) @(negedge clk);
    send(0, 7'h73, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, tx_start, active, locked, grant_id, tx_data} !== 17'b0) begin
      errors++; $display("FAIL midrst_outputs: got ready=%b start=%b active=%b locked=%b id=%0d data=%h want all 0",
                         req_ready, tx_start, active, locked, grant_id, tx_data);
    end
    rst = 1'b0;
    early = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0 || tx_start) early++;
      if (!tx_busy) break;
    end
    checks++;
    if (early != 0 || tx_busy) begin errors++; $display("FAIL midrst_hold: got early=%0d busy=%b want 0/0", early, tx_busy); end
    wait_ready(20, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin errors++; $display("FAIL midrst_next_ready: no grant after frame end"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_next_onehot: got %b want 0001", req_ready); end
      @(negedge clk);
      checks++;
      if ({tx_start, grant_id, tx_data} !== {1'b1, e}) begin errors++; $display("FAIL midrst_next_frame: got %h want %h", {grant_id, tx_data}, e); end
    end
    wait_idle(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_idle: did not return idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_locked();
    test_nostart();
    test_lock_stall();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
